// File: rtl/rf_access_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rf_ctrl_pkg
// Shared definitions for the register-file access controller:
//   - 3-bit opcode encodings (OP_NOP .. OP_XOR)
//   - FSM state encodings for the execute/writeback sequencer
// ----------------------------------------------------------------------------
package rf_ctrl_pkg;

    // Opcodes carried on instr_op.
    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_MOVI = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_OR   = 3'd6;
    localparam logic [2:0] OP_XOR  = 3'd7;

    // Sequencer states. The encodings are kept as plain constants so the
    // state register can be probed as a bare 2-bit vector.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    // True for every opcode that writes its result back to the register file.
    function automatic logic op_writes(input logic [2:0] op);
        return op != OP_NOP;
    endfunction

endpackage

// File: rtl/rf_access_ctrl_if.sv
// ----------------------------------------------------------------------------
// rf_access_ctrl_if
// Instruction handshake between the decoder (master) and the register-file
// access controller (slave).
//   instr_valid  master->slave  instruction offered
//   instr_ready  slave->master  controller can accept an instruction
//   instr_op     master->slave  opcode (rf_ctrl_pkg::OP_*)
//   instr_rd     master->slave  destination register
//   instr_rsA    master->slave  source A register
//   instr_rsB    master->slave  source B register
//   instr_imm    master->slave  immediate for MOVI
// ----------------------------------------------------------------------------
interface rf_access_ctrl_if #(
    parameter int BUS_WIDTH = 16
);

    logic                 instr_valid;
    logic                 instr_ready;
    logic [2:0]           instr_op;
    logic [2:0]           instr_rd;
    logic [2:0]           instr_rsA;
    logic [2:0]           instr_rsB;
    logic [BUS_WIDTH-1:0] instr_imm;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rsA, instr_rsB, instr_imm,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rsA, instr_rsB, instr_imm,
        output instr_ready
    );

endinterface

// File: rtl/rf_access_ctrl_alu.sv
// ----------------------------------------------------------------------------
// rf_ctrl_alu
// Single-cycle combinational ALU for the register-file access controller.
//   op      in   3          opcode (rf_ctrl_pkg::OP_*)
//   A       in   BUS_WIDTH  source A operand
//   B       in   BUS_WIDTH  source B operand
//   imm     in   BUS_WIDTH  immediate (MOVI)
//   result  out  BUS_WIDTH  result, modulo 2^BUS_WIDTH (carry/borrow dropped)
// ----------------------------------------------------------------------------
module rf_ctrl_alu
    import rf_ctrl_pkg::*;
#(
    parameter int BUS_WIDTH = 16
) (
    input  logic [2:0]           op,
    input  logic [BUS_WIDTH-1:0] A,
    input  logic [BUS_WIDTH-1:0] B,
    input  logic [BUS_WIDTH-1:0] imm,
    output logic [BUS_WIDTH-1:0] result
);

    always_comb begin
        // NOTE: result gets a default before the case so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        result = '0;
        case (op)
            OP_MOV:  result = A;
            OP_MOVI: result = imm;
            OP_ADD:  result = A + B;
            OP_SUB:  result = A - B;
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_XOR:  result = A ^ B;
            default: result = '0;  // OP_NOP
        endcase
    end

endmodule

// File: rtl/rf_access_ctrl.sv
// ----------------------------------------------------------------------------
// rf_access_ctrl
// Execute/writeback sequencer sitting between the decoder and a register file
// with registered read ports. Accepts one instruction at a time, reads both
// sources, computes the ALU result and writes it back to rd.
//   clk       in   1          rising-edge clock, shared with the register file
//   rst       in   1          synchronous reset, active-high
//   instr     slave           instruction handshake (rf_access_ctrl_if)
//   rsA/rsB   out  3          register file read selects (registered)
//   A/B       in   BUS_WIDTH  register file read data, one clk after rsA/rsB
//   regWrite  out  1          register file write enable
//   rd        out  3          register file write select (registered)
//   D         out  BUS_WIDTH  register file write data (registered)
//   done      out  1          one-cycle pulse when an instruction retires
//   result    out  BUS_WIDTH  last computed result, held until next retirement
// Sequence: IDLE -accept-> READ -> EXEC -> WRITE -> IDLE (NOP skips WRITE).
// ----------------------------------------------------------------------------
module rf_access_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int BUS_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rf_access_ctrl_if.slave      instr,
    output logic [2:0]           rsA,
    output logic [2:0]           rsB,
    input  logic [BUS_WIDTH-1:0] A,
    input  logic [BUS_WIDTH-1:0] B,
    output logic                 regWrite,
    output logic [2:0]           rd,
    output logic [BUS_WIDTH-1:0] D,
    output logic                 done,
    output logic [BUS_WIDTH-1:0] result
);

    logic [1:0]           state_q, state_d;
    logic [2:0]           op_q;
    logic [2:0]           rd_lat_q;   // rd captured at accept, published at EXEC exit
    logic [BUS_WIDTH-1:0] imm_q;
    logic [2:0]           rsA_q, rsB_q, rd_q;
    logic [BUS_WIDTH-1:0] D_q, result_q;
    logic                 regWrite_q, done_q;
    logic [BUS_WIDTH-1:0] alu_result;
    logic                 accept;

    assign instr.instr_ready = (state_q == ST_IDLE) && !rst;
    assign accept            = instr.instr_valid && instr.instr_ready;

    rf_ctrl_alu #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_alu (
        .op     (op_q),
        .A      (A),
        .B      (B),
        .imm    (imm_q),
        .result (alu_result)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_READ;
            ST_READ:  state_d = ST_EXEC;
            ST_EXEC:  state_d = op_writes(op_q) ? ST_WRITE : ST_IDLE;
            default:  state_d = ST_IDLE;  // ST_WRITE
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge value of every other; blocking would create
    // order-dependent simulation that no longer matches the netlist.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NOP;
            rd_lat_q   <= '0;
            imm_q      <= '0;
            rsA_q      <= '0;
            rsB_q      <= '0;
            rd_q       <= '0;
            D_q        <= '0;
            result_q   <= '0;
            regWrite_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            // regWrite and done are pulses; they default low every cycle.
            regWrite_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q     <= instr.instr_op;
                        rd_lat_q <= instr.instr_rd;
                        imm_q    <= instr.instr_imm;
                        rsA_q    <= instr.instr_rsA;
                        rsB_q    <= instr.instr_rsB;
                    end
                end
                ST_EXEC: begin
                    // A/B are valid now; publish the result. done lands in
                    // WRITE for writing ops, or in the following IDLE for NOP.
                    D_q        <= alu_result;
                    rd_q       <= rd_lat_q;
                    result_q   <= alu_result;
                    regWrite_q <= op_writes(op_q);
                    done_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Gating with rst keeps a write (or retirement) from being visible on the
    // very edge where reset aborts the instruction.
    assign regWrite = regWrite_q && !rst;
    assign done     = done_q && !rst;
    assign rsA      = rsA_q;
    assign rsB      = rsB_q;
    assign rd       = rd_q;
    assign D        = D_q;
    assign result   = result_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rf_access_ctrl
// Directed bench for rf_access_ctrl with a behavioural 8-entry register file
// whose read ports are registered (A/B valid one clk after rsA/rsB sampled).
// ----------------------------------------------------------------------------
module tb_rf_access_ctrl;
    import rf_ctrl_pkg::*;

    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rf_clr = 1'b1;
    logic [2:0]    rsA, rsB, rd;
    logic [BW-1:0] A, B, D, result;
    logic          regWrite, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_access_ctrl_if #(.BUS_WIDTH(BW)) instr_if ();

    rf_access_ctrl #(.BUS_WIDTH(BW)) dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr_if.slave),
        .rsA      (rsA),
        .rsB      (rsB),
        .A        (A),
        .B        (B),
        .regWrite (regWrite),
        .rd       (rd),
        .D        (D),
        .done     (done),
        .result   (result)
    );

    // Register file model: registered reads, write commits at the posedge.
    logic [BW-1:0] rf [8];
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else if (regWrite) begin
            rf[rd] <= D;
        end
        A <= rf[rsA];
        B <= rf[rsB];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic offer(input logic [2:0] op, input logic [2:0] rdn,
                         input logic [2:0] ra, input logic [2:0] rb,
                         input logic [BW-1:0] imm);
        instr_if.instr_op    = op;
        instr_if.instr_rd    = rdn;
        instr_if.instr_rsA   = ra;
        instr_if.instr_rsB   = rb;
        instr_if.instr_imm   = imm;
        instr_if.instr_valid = 1'b1;
    endtask

    // Called at a negedge with an instruction offered; returns just after the
    // accepting posedge.
    task automatic wait_accept(input bit drop_valid);
        int n = 0;
        while (!instr_if.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < 20), 32'd1);
        @(posedge clk);
        #1;
        if (drop_valid) instr_if.instr_valid = 1'b0;
    endtask

    // Issues one instruction and checks every cycle up to retirement.
    task automatic run(input string tag, input logic [2:0] op, input logic [2:0] rdn,
                       input logic [2:0] ra, input logic [2:0] rb,
                       input logic [BW-1:0] imm, input logic [BW-1:0] exp_d);
        logic [BW-1:0] old_val;
        old_val = rf[rdn];
        @(negedge clk);
        offer(op, rdn, ra, rb, imm);
        wait_accept(1'b1);
        @(negedge clk);  // READ
        check({tag, "_read_ready"}, 32'(instr_if.instr_ready), 32'd0);
        check({tag, "_read_rsA"}, 32'(rsA), 32'(ra));
        check({tag, "_read_rsB"}, 32'(rsB), 32'(rb));
        @(negedge clk);  // EXEC
        check({tag, "_exec_wr"}, 32'(regWrite), 32'd0);
        check({tag, "_exec_done"}, 32'(done), 32'd0);
        if (op != OP_NOP) begin
            @(negedge clk);  // WRITE
            check({tag, "_wb_wr"}, 32'(regWrite), 32'd1);
            check({tag, "_wb_done"}, 32'(done), 32'd1);
            check({tag, "_wb_rd"}, 32'(rd), 32'(rdn));
            check({tag, "_wb_D"}, 32'(D), 32'(exp_d));
            check({tag, "_wb_result"}, 32'(result), 32'(exp_d));
            @(negedge clk);  // IDLE
            check({tag, "_idle_wr"}, 32'(regWrite), 32'd0);
            check({tag, "_idle_done"}, 32'(done), 32'd0);
            check({tag, "_idle_ready"}, 32'(instr_if.instr_ready), 32'd1);
            check({tag, "_rf"}, 32'(rf[rdn]), 32'(exp_d));
        end else begin
            @(negedge clk);  // IDLE, retirement pulse
            check({tag, "_done"}, 32'(done), 32'd1);
            check({tag, "_wr"}, 32'(regWrite), 32'd0);
            check({tag, "_ready"}, 32'(instr_if.instr_ready), 32'd1);
            @(negedge clk);
            check({tag, "_done_end"}, 32'(done), 32'd0);
            check({tag, "_wr_end"}, 32'(regWrite), 32'd0);
            check({tag, "_rf_keep"}, 32'(rf[rdn]), 32'(old_val));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held 2 cycles with an instruction offered.
        offer(OP_MOVI, 3'd3, 3'd5, 3'd6, 16'hBEEF);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_ready", 32'(instr_if.instr_ready), 32'd0);
            check("rst_wr", 32'(regWrite), 32'd0);
            check("rst_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        rf_clr = 1'b0;
        instr_if.instr_valid = 1'b0;
        #1;
        check("post_rst_ready", 32'(instr_if.instr_ready), 32'd1);
        check("post_rst_rsA", 32'(rsA), 32'd0);
        check("post_rst_rsB", 32'(rsB), 32'd0);
        check("post_rst_rd", 32'(rd), 32'd0);
        check("post_rst_D", 32'(D), 32'd0);
        check("post_rst_result", 32'(result), 32'd0);
        @(negedge clk);
        check("post_rst_idle", 32'(instr_if.instr_ready), 32'd1);

        // MOVI then MOV reading it back.
        run("movi_r3", OP_MOVI, 3'd3, 3'd5, 3'd6, 16'h1234, 16'h1234);
        run("mov_r0",  OP_MOV,  3'd0, 3'd3, 3'd0, 16'h0000, 16'h1234);

        // ALU corner values.
        run("movi_r1", OP_MOVI, 3'd1, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF);
        run("movi_r2", OP_MOVI, 3'd2, 3'd1, 3'd1, 16'h0002, 16'h0002);
        run("add_r4",  OP_ADD,  3'd4, 3'd1, 3'd2, 16'h0000, 16'h0001);
        run("sub_r5",  OP_SUB,  3'd5, 3'd2, 3'd1, 16'h0000, 16'h0003);
        run("xor_r6",  OP_XOR,  3'd6, 3'd1, 3'd2, 16'h0000, 16'hFFFD);
        run("and_r3",  OP_AND,  3'd3, 3'd1, 3'd2, 16'h0000, 16'h0002);
        run("or_r0",   OP_OR,   3'd0, 3'd1, 3'd2, 16'h0000, 16'hFFFF);

        // Dependent back-to-back pair with valid held high throughout.
        @(negedge clk);
        offer(OP_MOVI, 3'd6, 3'd0, 3'd0, 16'h00AA);
        wait_accept(1'b0);
        offer(OP_MOV, 3'd7, 3'd6, 3'd6, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("b2b_busy", 32'(instr_if.instr_ready), 32'd0);
        end
        check("b2b_first_wr", 32'(regWrite), 32'd1);
        check("b2b_first_D", 32'(D), 32'h00AA);
        @(negedge clk);
        check("b2b_idle_ready", 32'(instr_if.instr_ready), 32'd1);
        check("b2b_idle_done", 32'(done), 32'd0);
        @(posedge clk);
        #1 instr_if.instr_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_read", 32'(instr_if.instr_ready), 32'd0);
        check("b2b_second_rsA", 32'(rsA), 32'd6);
        @(negedge clk);
        @(negedge clk);
        check("b2b_second_wr", 32'(regWrite), 32'd1);
        check("b2b_second_rd", 32'(rd), 32'd7);
        check("b2b_second_D", 32'(D), 32'h00AA);
        @(negedge clk);
        check("b2b_rf_r7", 32'(rf[7]), 32'h00AA);

        // NOP with rd=5: retires without writing.
        run("nop_r5", OP_NOP, 3'd5, 3'd1, 3'd2, 16'h5555, 16'h0000);

        // Reset during WRITE of ADD r4 = r2 + r2 (would give 4, r4 holds 1).
        @(negedge clk);
        offer(OP_ADD, 3'd4, 3'd2, 3'd2, 16'h0000);
        wait_accept(1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);  // WRITE
        check("abort_pre_wr", 32'(regWrite), 32'd1);
        check("abort_pre_D", 32'(D), 32'h0004);
        rst = 1'b1;
        #1;
        check("abort_wr_gated", 32'(regWrite), 32'd0);
        check("abort_done_gated", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready", 32'(instr_if.instr_ready), 32'd1);
        check("abort_rf_r4", 32'(rf[4]), 32'h0001);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        check("abort_idle_wr", 32'(regWrite), 32'd0);
        check("abort_idle_done", 32'(done), 32'd0);
        check("abort_rf_r4_hold", 32'(rf[4]), 32'h0001);

        // Controller recovers after the aborted instruction.
        run("mov_r0_r4", OP_MOV, 3'd0, 3'd4, 3'd4, 16'h0000, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
